// File: rtl/rv_mem_resp.sv
// Instruction/data word memories for a small RV core, with a beat-based preload
// port and sticky error flags for misaligned or out-of-range accesses.
module rv_mem_resp #(
  parameter int DPWIDTH    = 32,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] imem_addr,
  output logic [DPWIDTH-1:0] imem_datain,
  input  logic [DPWIDTH-1:0] dmem_addr,
  input  logic [DPWIDTH-1:0] dmem_dataout,
  input  logic               memrw,
  output logic [DPWIDTH-1:0] dmem_datain,
  input  logic               ld_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_sel,
  input  logic [DPWIDTH-1:0] ld_addr,
  input  logic [DPWIDTH-1:0] ld_data,
  input  logic               ld_last,
  output logic               ld_active,
  output logic               ld_done,
  output logic [15:0]        wr_count,
  output logic               err_misalign,
  output logic               err_oob
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {IDLE, LOADING, DONE} ld_state_t;
  ld_state_t state;

  logic [DPWIDTH-1:0] imem [IMEM_WORDS];
  logic [DPWIDTH-1:0] dmem [DMEM_WORDS];

  logic           imem_oob, dmem_oob, ld_oob;
  logic [IAW-1:0] imem_idx, ld_imem_idx;
  logic [DAW-1:0] dmem_idx, ld_dmem_idx;
  logic           beat, cpu_try, cpu_misal, cpu_wr;
  logic           ld_addr_unused;

  // Depths are powers of two, so "word index >= depth" is any set bit above the index field.
  assign imem_oob    = |imem_addr[DPWIDTH-1:IAW+2];
  assign dmem_oob    = |dmem_addr[DPWIDTH-1:DAW+2];
  assign ld_oob      = ld_sel ? |ld_addr[DPWIDTH-1:DAW+2] : |ld_addr[DPWIDTH-1:IAW+2];
  assign imem_idx    = imem_addr[IAW+1:2];
  assign dmem_idx    = dmem_addr[DAW+1:2];
  assign ld_imem_idx = ld_addr[IAW+1:2];
  assign ld_dmem_idx = ld_addr[DAW+1:2];
  assign ld_addr_unused = ^ld_addr[1:0];

  assign beat      = ld_valid && ld_ready;
  assign cpu_try   = memrw && !ld_active;
  assign cpu_misal = dmem_addr[1:0] != 2'b00;
  assign cpu_wr    = cpu_try && !cpu_misal && !dmem_oob;

  assign imem_datain = imem_oob ? '0 : imem[imem_idx];
  assign dmem_datain = dmem_oob ? '0 : dmem[dmem_idx];

  // Memory contents deliberately survive reset; only the write enables are gated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (beat && !ld_oob && !ld_sel) imem[ld_imem_idx] <= ld_data;
      if (beat && !ld_oob && ld_sel) dmem[ld_dmem_idx] <= ld_data;
      else if (cpu_wr) dmem[dmem_idx] <= dmem_dataout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ld_active    <= 1'b0;
      ld_ready     <= 1'b0;
      ld_done      <= 1'b0;
      wr_count     <= 16'd0;
      err_misalign <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: if (ld_start) begin
          state     <= LOADING;
          ld_active <= 1'b1;
          ld_ready  <= 1'b1;
        end
        LOADING: if (beat && ld_last) begin
          state     <= DONE;
          ld_active <= 1'b0;
          ld_ready  <= 1'b0;
          ld_done   <= 1'b1;
        end
        DONE: state <= IDLE;
        default: begin
          state     <= IDLE;
          ld_active <= 1'b0;
          ld_ready  <= 1'b0;
        end
      endcase
      if (cpu_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if ((cpu_try && cpu_misal) || (!ld_active && imem_addr[1:0] != 2'b00)) err_misalign <= 1'b1;
      if ((cpu_try && dmem_oob) || (beat && ld_oob)) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_mem_resp.sv
// Randomized bench for rv_mem_resp against a word-array reference model,
// plus directed preload / store / error / reset scenarios and counter saturation.
module tb_rv_mem_resp;
  localparam int W  = 32;
  localparam int IW = 256;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] imem_addr, imem_datain, dmem_addr, dmem_dataout, dmem_datain;
  logic memrw, ld_start, ld_valid, ld_ready, ld_sel, ld_last, ld_active, ld_done;
  logic [W-1:0] ld_addr, ld_data;
  logic [15:0] wr_count;
  logic err_misalign, err_oob;

  always #5 clk = ~clk;

  rv_mem_resp #(.DPWIDTH(W), .IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_datain(imem_datain),
    .dmem_addr(dmem_addr), .dmem_dataout(dmem_dataout), .memrw(memrw),
    .dmem_datain(dmem_datain),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_active(ld_active), .ld_done(ld_done), .wr_count(wr_count),
    .err_misalign(err_misalign), .err_oob(err_oob)
  );

  // reference model: plain word arrays with "known" bits, session flags, counters
  logic [W-1:0] im_m [IW];
  logic [W-1:0] dm_m [DW];
  bit im_v [IW];
  bit dm_v [DW];
  bit sess, done_m, mis_m, oob_m;
  int unsigned cnt_m;

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned widx(logic [W-1:0] a);
    return int'(a >> 2);
  endfunction

  task automatic model_update();
    bit was_done;
    int unsigned i;
    if (rst) begin
      sess = 0; done_m = 0; mis_m = 0; oob_m = 0; cnt_m = 0;
      return;
    end
    was_done = done_m;
    done_m = 0;
    if (sess) begin
      if (ld_valid) begin
        i = widx(ld_addr);
        if (i >= (ld_sel ? DW : IW)) oob_m = 1;
        else if (ld_sel) begin dm_m[i] = ld_data; dm_v[i] = 1; end
        else begin im_m[i] = ld_data; im_v[i] = 1; end
        if (ld_last) begin sess = 0; done_m = 1; end
      end
    end else begin
      if (memrw) begin
        i = widx(dmem_addr);
        if (dmem_addr[1:0] != 0) mis_m = 1;
        if (i >= DW) oob_m = 1;
        if (dmem_addr[1:0] == 0 && i < DW) begin
          dm_m[i] = dmem_dataout; dm_v[i] = 1;
          if (cnt_m < 65535) cnt_m++;
        end
      end
      if (imem_addr[1:0] != 0) mis_m = 1;
      if (!was_done && ld_start) sess = 1;
    end
  endtask

  task automatic check_reads();
    int unsigned i;
    i = widx(imem_addr);
    if (i >= IW) chk("imem_oob_rd", imem_datain, '0);
    else if (im_v[i]) chk("imem_rd", imem_datain, im_m[i]);
    i = widx(dmem_addr);
    if (i >= DW) chk("dmem_oob_rd", dmem_datain, '0);
    else if (dm_v[i]) chk("dmem_rd", dmem_datain, dm_m[i]);
  endtask

  task automatic check_regs();
    chk("ld_active", W'(ld_active), W'(sess));
    chk("ld_ready", W'(ld_ready), W'(sess));
    chk("ld_done", W'(ld_done), W'(done_m));
    chk("wr_count", W'(wr_count), cnt_m);
    chk("err_misalign", W'(err_misalign), W'(mis_m));
    chk("err_oob", W'(err_oob), W'(oob_m));
  endtask

  // inputs are set just after a negedge; reads checked before the edge, state after it
  task automatic cycle(bit do_chk);
    #1;
    if (do_chk) check_reads();
    @(posedge clk);
    model_update();
    #1;
    if (do_chk) check_regs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; memrw = 0; ld_start = 0; ld_valid = 0; ld_sel = 0; ld_last = 0;
    imem_addr = 0; dmem_addr = 0; dmem_dataout = 0; ld_addr = 0; ld_data = 0;
  endtask

  function automatic logic [W-1:0] rand_addr(int depth);
    int unsigned r;
    logic [W-1:0] a;
    r = $urandom_range(0, 15);
    a = W'($urandom_range(0, 31)) << 2;
    if (r == 0) a = a | W'($urandom_range(1, 3));
    else if (r == 1) a = W'(depth * 4) + a;
    return a;
  endfunction

  initial begin
    idle_inputs();
    rst = 1;
    cycle(1);
    chk("rst_wr_count", W'(wr_count), 0);
    rst = 0;

    // preload two IMEM words
    ld_start = 1; cycle(1); ld_start = 0;
    ld_valid = 1; ld_sel = 0; ld_addr = 32'h0; ld_data = 32'h00500093; cycle(1);
    ld_addr = 32'h4; ld_data = 32'h00A00113; ld_last = 1; cycle(1);
    chk("preload_done_hi", W'(ld_done), 1);
    ld_valid = 0; ld_last = 0; imem_addr = 32'h4;
    #1 chk("preload_word1", imem_datain, 32'h00A00113);
    cycle(1);
    chk("preload_done_lo", W'(ld_done), 0);

    // store then load
    memrw = 1; dmem_addr = 32'h10; dmem_dataout = 32'hDEADBEEF; cycle(1);
    memrw = 0;
    #1 chk("store_load", dmem_datain, 32'hDEADBEEF);
    chk("store_cnt", W'(wr_count), 1);

    // misaligned store
    memrw = 1; dmem_addr = 32'h12; dmem_dataout = 32'h11111111; cycle(1);
    memrw = 0; dmem_addr = 32'h10;
    #1 chk("misal_unchanged", dmem_datain, 32'hDEADBEEF);
    chk("misal_flag", W'(err_misalign), 1);
    chk("misal_cnt", W'(wr_count), 1);

    // out-of-range store
    memrw = 1; dmem_addr = 32'h400; dmem_dataout = 32'h22222222; cycle(1);
    memrw = 0;
    #1 chk("oob_flag", W'(err_oob), 1);
    chk("oob_read0", dmem_datain, 0);

    // seed 0x20, then store to it during a session
    memrw = 1; dmem_addr = 32'h20; dmem_dataout = 32'hCAFE0020; cycle(1);
    memrw = 0; ld_start = 1; cycle(1); ld_start = 0;
    memrw = 1; dmem_addr = 32'h20; dmem_dataout = 32'h33333333; cycle(1);
    memrw = 0;
    #1 chk("sess_store_drop", dmem_datain, 32'hCAFE0020);
    chk("sess_store_cnt", W'(wr_count), 2);
    rst = 1; cycle(1); rst = 0;
    chk("rst_ready", W'(ld_ready), 0);
    chk("rst_active", W'(ld_active), 0);
    chk("rst_flags", W'({err_misalign, err_oob}), 0);
    chk("rst_cnt", W'(wr_count), 0);
    imem_addr = 32'h4;
    #1 chk("rst_mem_kept", imem_datain, 32'h00A00113);
    cycle(1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      ld_start = ($urandom_range(0, 9) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_sel = $urandom_range(0, 1);
      ld_addr = rand_addr(ld_sel ? DW : IW);
      ld_data = $urandom;
      ld_last = ($urandom_range(0, 5) == 0);
      memrw = $urandom_range(0, 1);
      dmem_addr = rand_addr(DW);
      dmem_dataout = $urandom;
      imem_addr = ($urandom_range(0, 19) == 0) ? rand_addr(IW) : W'($urandom_range(0, 31)) << 2;
      cycle(1);
    end

    // counter saturation
    idle_inputs();
    rst = 1; cycle(1); rst = 0;
    memrw = 1; dmem_addr = 32'h40;
    for (int n = 0; n < 65540; n++) begin
      dmem_dataout = W'(n);
      cycle(0);
    end
    memrw = 0;
    chk("wr_count_sat", W'(wr_count), 32'h0000FFFF);
    cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_mem_resp.md
RV_MEM_RESP -- requirements
Module: rv_mem_resp

Interface
REQ-001 SHALL have parameter DPWIDTH, default 32, datapath and memory word width in bits.
REQ-002 SHALL have parameter IMEM_WORDS, default 256, instruction memory depth in words (power of 2).
REQ-003 SHALL have parameter DMEM_WORDS, default 256, data memory depth in words (power of 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port imem_addr  input  DPWIDTH  CPU instruction byte address.
REQ-007 SHALL have port imem_datain  output  DPWIDTH  instruction word returned to CPU.
REQ-008 SHALL have port dmem_addr  input  DPWIDTH  CPU data byte address.
REQ-009 SHALL have port dmem_dataout  input  DPWIDTH  CPU store data.
REQ-010 SHALL have port memrw  input  1  1 = CPU store this cycle, 0 = read.
REQ-011 SHALL have port dmem_datain  output  DPWIDTH  load data returned to CPU.
REQ-012 SHALL have port ld_start  input  1  pulse requesting a preload session.
REQ-013 SHALL have ports ld_valid input 1, ld_ready output 1, ld_sel input 1 (0 = IMEM, 1 = DMEM), ld_addr input DPWIDTH (byte address), ld_data input DPWIDTH, ld_last input 1: the loader beat handshake.
REQ-014 SHALL have ports ld_active output 1, ld_done output 1, wr_count output 16, err_misalign output 1, err_oob output 1.

Function
REQ-015 SHALL index memories by word: index = addr[log2(depth)+1:2]; an address is out of range when addr[DPWIDTH-1:2] >= depth.
REQ-016 SHALL drive imem_datain and dmem_datain combinationally from the current address with zero added latency; an out-of-range address returns 0.
REQ-017 SHALL perform a CPU store on the rising edge when memrw=1, ld_active=0, the address is in range and dmem_addr[1:0]=0; all other CPU stores are dropped.
REQ-018 SHALL make a store visible on dmem_datain in the cycle after the write edge; same-cycle read-during-write returns old data.
REQ-019 SHALL increment wr_count once per performed CPU store and saturate at 16'hFFFF.
REQ-020 SHALL set err_misalign (sticky) on a dropped CPU store with dmem_addr[1:0]!=0, or when imem_addr[1:0]!=0 while ld_active=0.
REQ-021 SHALL set err_oob (sticky) on a CPU store or accepted loader beat whose address is out of range; that write is dropped.
REQ-022 SHALL implement loader FSM IDLE -> LOADING -> DONE -> IDLE.
REQ-023 SHALL move IDLE->LOADING on ld_start=1; ld_start in any other state is ignored.
REQ-024 SHALL hold ld_active=1 and ld_ready=1 in LOADING only.
REQ-025 SHALL accept a beat on ld_valid&&ld_ready, writing ld_data to the memory chosen by ld_sel at that edge; misaligned ld_addr is written word-truncated, with no error.
REQ-026 SHALL move LOADING->DONE on an accepted beat with ld_last=1, and DONE->IDLE unconditionally after one cycle.
REQ-027 SHALL drive ld_done=1 for exactly the single DONE cycle.
REQ-028 SHALL drop, without counting or flagging, a CPU store issued while ld_active=1.

Reset
REQ-029 SHALL, while rst=1 at an edge: go to IDLE, clear wr_count, err_misalign, err_oob and ld_done, force ld_ready=0 and ld_active=0, and perform no memory write.
REQ-030 SHALL NOT alter memory contents on reset; rst during LOADING abandons the session, and beats already accepted remain written.

Verification
REQ-031 Preload: ld_start, then IMEM beats addr 0x0/0x4 with data 0x00500093/0x00A00113, last on the 2nd -> imem_datain=0x00A00113 at imem_addr=0x4, ld_done high for 1 cycle.
REQ-032 Store then load: memrw=1, dmem_addr=0x10, dmem_dataout=0xDEADBEEF -> dmem_datain=0xDEADBEEF from the next cycle, wr_count=1.
REQ-033 Misaligned store to 0x12 -> memory unchanged, err_misalign=1, wr_count unchanged.
REQ-034 Out-of-range store to 0x400 (DMEM_WORDS=256) -> dropped, err_oob=1; a read of 0x400 returns 0.
REQ-035 CPU store to 0x20 during LOADING -> dropped, no flag; rst asserted mid-session -> next cycle IDLE, ld_ready=0, flags and wr_count cleared, preloaded words intact.
